// File: rtl/mult_cdb_buffer_if.sv
// Handshake bundle tying the issue stage, the mult unit outputs and the CDB
// arbiter to mult_cdb_buffer. The buffer uses the slave view.
interface mult_cdb_buffer_if #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  logic              issue_valid;
  logic [TAG_W-1:0]  issue_tag;
  logic              issue_ready;
  logic              squash;
  logic              mult_done;
  logic [DATA_W-1:0] mult_result;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_grant;
  logic              error;

  modport master (
    output issue_valid, issue_tag, squash, mult_done, mult_result, cdb_grant,
    input  issue_ready, cdb_valid, cdb_tag, cdb_value, error
  );

  modport slave (
    input  issue_valid, issue_tag, squash, mult_done, mult_result, cdb_grant,
    output issue_ready, cdb_valid, cdb_tag, cdb_value, error
  );
endinterface

// File: rtl/mult_cdb_buffer.sv
// Completion buffer behind the non-stallable multiplier: tracks tags alongside
// the mult pipeline, queues finished results and hands them to the CDB on grant.
`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif

module mult_cdb_buffer #(
  parameter int STAGES = `MULT_STAGES,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input logic              clock,
  input logic              reset,
  mult_cdb_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = $clog2(DEPTH + STAGES + 1);

  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] c;
    c = {OCC_W{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      c = c + OCC_W'(v[i]);
    end
    return c;
  endfunction

  // Tracking pipeline, plus a shadow of ops killed by squash that the mult
  // unit will still finish; their done pulses are expected, not errors.
  logic [STAGES-1:0] trk_vld_q, trk_vld_d;
  logic [STAGES-1:0] ghost_q, ghost_d;
  logic [TAG_W-1:0]  trk_tag_q [STAGES];

  logic [TAG_W-1:0]  tag_mem_q [DEPTH];
  logic [DATA_W-1:0] val_mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [OCC_W-1:0]  inflight_s;
  logic [OCC_W-1:0]  occ_s;
  logic              issue_ready_s;
  logic              cdb_valid_s;
  logic              started_s;
  logic              fire_s;
  logic              cap_vld_s;
  logic              push_s;
  logic              pop_s;
  logic              mismatch_s;

  // Handshake decode; credit and CDB valid come from registered state only
  always_comb begin
    inflight_s    = popcount(trk_vld_q);
    occ_s         = OCC_W'(cnt_q) + inflight_s;
    issue_ready_s = (occ_s < DEPTH_OCC);
    cdb_valid_s   = (cnt_q != CNT_ZERO);
    started_s     = bus.issue_valid && issue_ready_s;
    fire_s        = started_s && !bus.squash;
    cap_vld_s     = trk_vld_q[STAGES-1];
    push_s        = cap_vld_s && !bus.squash;
    pop_s         = cdb_valid_s && bus.cdb_grant;
    if (cap_vld_s) begin
      mismatch_s = !bus.mult_done;
    end else begin
      mismatch_s = bus.mult_done && !ghost_q[STAGES-1];
    end
  end

  // Tracking and squash-shadow next state
  always_comb begin
    trk_vld_d = {STAGES{1'b0}};
    ghost_d   = {STAGES{1'b0}};
    if (bus.squash) begin
      ghost_d[0] = started_s;
      for (int k = 1; k < STAGES; k++) begin
        ghost_d[k] = ghost_q[k-1] | trk_vld_q[k-1];
      end
    end else begin
      trk_vld_d[0] = fire_s;
      for (int k = 1; k < STAGES; k++) begin
        trk_vld_d[k] = trk_vld_q[k-1];
        ghost_d[k]   = ghost_q[k-1];
      end
    end
  end

  // FIFO pointer/count next state; squash discards everything after the pop
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (bus.squash) begin
      head_d = PTR_ZERO;
      tail_d = PTR_ZERO;
      cnt_d  = CNT_ZERO;
    end else begin
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Sticky consistency flag
  always_comb begin
    err_d = err_q | mismatch_s;
  end

  // Control state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trk_vld_q <= {STAGES{1'b0}};
      ghost_q   <= {STAGES{1'b0}};
      head_q    <= PTR_ZERO;
      tail_q    <= PTR_ZERO;
      cnt_q     <= CNT_ZERO;
      err_q     <= 1'b0;
    end else begin
      trk_vld_q <= trk_vld_d;
      ghost_q   <= ghost_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Payload storage; qualified by the valid bits above so it needs no reset
  always_ff @(posedge clock) begin
    trk_tag_q[0] <= bus.issue_tag;
    for (int k = 1; k < STAGES; k++) begin
      trk_tag_q[k] <= trk_tag_q[k-1];
    end
    if (push_s) begin
      tag_mem_q[tail_q] <= trk_tag_q[STAGES-1];
      val_mem_q[tail_q] <= bus.mult_result;
    end
  end

  // Head is gated so an empty FIFO presents zeros instead of stale entries
  assign bus.issue_ready = issue_ready_s;
  assign bus.cdb_valid   = cdb_valid_s;
  assign bus.cdb_tag     = cdb_valid_s ? tag_mem_q[head_q] : {TAG_W{1'b0}};
  assign bus.cdb_value   = cdb_valid_s ? val_mem_q[head_q] : {DATA_W{1'b0}};
  assign bus.error       = err_q;

endmodule

// File: tb/tb_mult_cdb_buffer.sv
// Directed bench for mult_cdb_buffer: an op-level model (queues of in-flight
// multiplies and queued results) is compared every cycle, plus literal checks.
module tb_mult_cdb_buffer;
  localparam int STAGES = 4;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mult_cdb_buffer_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  mult_cdb_buffer #(
    .STAGES(STAGES), .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    int                due;
    bit                tracked;
  } op_t;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } ent_t;

  op_t               pipe [$];
  ent_t              fifo [$];
  logic [TAG_W-1:0]  delivered [$];
  bit                exp_err;
  int                cyc;
  int                pass_cnt;
  int                total_cnt;
  bit                seen_valid;

  logic              s_valid, s_ready, s_err;
  logic [TAG_W-1:0]  s_tag;
  logic [DATA_W-1:0] s_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_ready();
    int n;
    n = 0;
    foreach (pipe[i]) begin
      if (pipe[i].tracked) n++;
    end
    return (fifo.size() + n) < DEPTH;
  endfunction

  task automatic compare();
    logic [TAG_W-1:0]  et;
    logic [DATA_W-1:0] ev;
    s_valid = bus.cdb_valid;
    s_ready = bus.issue_ready;
    s_err   = bus.error;
    s_tag   = bus.cdb_tag;
    s_val   = bus.cdb_value;
    et = '0;
    ev = '0;
    if (fifo.size() != 0) begin
      et = fifo[0].tag;
      ev = fifo[0].val;
    end
    check("issue_ready", s_ready, model_ready());
    check("cdb_valid", s_valid, fifo.size() != 0);
    check("cdb_tag", s_tag, et);
    check("cdb_value", s_val, ev);
    check("error", s_err, exp_err);
  endtask

  // One clock cycle: drive inputs (plus the mult unit's outputs), compare at
  // negedge, then advance the model across the posedge.
  task automatic tick(input bit iv, input int tg, input int a, input int b,
                      input bit sq, input bit gr, input bit spur);
    bit done_now, trk_now, sq_now, rdy, start, fire, mism;
    logic [DATA_W-1:0] res;
    op_t o;
    bus.issue_valid = iv;
    bus.issue_tag   = TAG_W'(tg);
    bus.squash      = sq;
    bus.cdb_grant   = gr;
    done_now = 1'b0;
    trk_now  = 1'b0;
    sq_now   = 1'b0;
    res      = $urandom;
    foreach (pipe[i]) begin
      if (pipe[i].due == cyc) begin
        done_now = 1'b1;
        res      = pipe[i].val;
        if (pipe[i].tracked) trk_now = 1'b1;
        else sq_now = 1'b1;
      end
    end
    bus.mult_done   = done_now | spur;
    bus.mult_result = res;
    @(negedge clock);
    compare();
    if (s_valid) seen_valid = 1'b1;
    if (s_valid && gr) delivered.push_back(s_tag);
    rdy = model_ready();
    @(posedge clock);
    mism  = trk_now ? !(done_now | spur) : ((done_now | spur) && !sq_now);
    start = iv && rdy;
    fire  = start && !sq;
    if (fifo.size() != 0 && gr) void'(fifo.pop_front());
    for (int i = pipe.size() - 1; i >= 0; i--) begin
      if (pipe[i].due == cyc) begin
        if (pipe[i].tracked && !sq) begin
          ent_t e;
          e.tag = pipe[i].tag;
          e.val = pipe[i].val;
          fifo.push_back(e);
        end
        pipe.delete(i);
      end
    end
    if (sq) begin
      fifo.delete();
      foreach (pipe[i]) pipe[i].tracked = 1'b0;
    end
    if (start) begin
      o.tag     = TAG_W'(tg);
      o.val     = DATA_W'(a * b);
      o.due     = cyc + STAGES;
      o.tracked = fire;
      pipe.push_back(o);
    end
    exp_err = exp_err | mism;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input bit gr);
    for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 0, 1'b0, gr, 1'b0);
  endtask

  task automatic clear_inputs();
    bus.issue_valid = 1'b0;
    bus.issue_tag   = '0;
    bus.squash      = 1'b0;
    bus.cdb_grant   = 1'b0;
    bus.mult_done   = 1'b0;
    bus.mult_result = '0;
  endtask

  task automatic reset_model();
    pipe.delete();
    fifo.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    cyc       = 0;
    exp_err   = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clock);
    #1;
    check("rst_cdb_valid", bus.cdb_valid, 1'b0);
    check("rst_cdb_tag", bus.cdb_tag, 6'd0);
    check("rst_cdb_value", bus.cdb_value, 32'd0);
    check("rst_issue_ready", bus.issue_ready, 1'b1);
    check("rst_error", bus.error, 1'b0);
    reset = 1'b0;

    // Single op: tag 5, 7*6, fired at cycle 10
    idle(10, 1'b0);
    tick(1'b1, 5, 7, 6, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("single_no_bypass", s_valid, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    check("single_valid", s_valid, 1'b1);
    check("single_tag", s_tag, 6'd5);
    check("single_value", s_val, 32'd42);
    idle(1, 1'b0);
    check("single_popped", s_valid, 1'b0);

    // Fill with grant low, then a simultaneous push/pop, then drain
    delivered.delete();
    for (int t = 1; t <= 4; t++) tick(1'b1, t, t, 10, 1'b0, 1'b0, 1'b0);
    check("fill_ready_4th", s_ready, 1'b1);
    tick(1'b1, 9, 9, 9, 1'b0, 1'b0, 1'b0);
    check("fill_ready_low", s_ready, 1'b0);
    idle(4, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    check("full_ready_at_pop", s_ready, 1'b0);
    tick(1'b1, 6, 6, 11, 1'b0, 1'b0, 1'b0);
    check("credit_after_pop", s_ready, 1'b1);
    idle(3, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    idle(5, 1'b1);
    check("drain_len", delivered.size(), 5);
    if (delivered.size() == 5) begin
      check("drain_0", delivered[0], 6'd1);
      check("drain_1", delivered[1], 6'd2);
      check("drain_2", delivered[2], 6'd3);
      check("drain_3", delivered[3], 6'd4);
      check("drain_4", delivered[4], 6'd6);
    end

    // Squash: two queued, two in flight, squash with grant of the head
    delivered.delete();
    tick(1'b1, 10, 10, 3, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 11, 11, 3, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    tick(1'b1, 12, 12, 3, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 13, 13, 3, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    check("squash_head_tag", s_tag, 6'd10);
    idle(1, 1'b1);
    check("squash_valid_next", s_valid, 1'b0);
    check("squash_ready_next", s_ready, 1'b1);
    idle(6, 1'b1);
    check("squash_no_error", s_err, 1'b0);
    check("squash_delivered", delivered.size(), 1);

    // Async reset mid-flight with four ops outstanding
    for (int t = 20; t <= 23; t++) tick(1'b1, t, t, 2, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_cdb_valid", bus.cdb_valid, 1'b0);
    check("midrst_issue_ready", bus.issue_ready, 1'b1);
    check("midrst_error", bus.error, 1'b0);
    check("midrst_cdb_tag", bus.cdb_tag, 6'd0);
    reset_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    cyc = cyc + 2;
    seen_valid = 1'b0;
    idle(10, 1'b0);
    check("midrst_no_result", seen_valid, 1'b0);

    // Spurious mult_done with nothing tracked
    tick(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("spur_not_yet", s_err, 1'b0);
    idle(1, 1'b0);
    check("spur_error_set", s_err, 1'b1);
    idle(5, 1'b0);
    check("spur_error_sticky", s_err, 1'b1);
    clear_inputs();
    reset = 1'b1;
    reset_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle(1, 1'b0);
    check("spur_error_cleared", s_err, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
